adc_sample_reader: RTL

//  Consumer end of the ADC conversion-start interface. Watches convst_bar (driven by the clock

---
 rtl/adc_sample_reader_pkg.sv | 33 +++
 rtl/adc_sample_reader_sync2.sv | 32 +++
 rtl/adc_sample_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_reader_pkg.sv
// ============================================================================
// Package : adc_sample_reader_pkg
// Brief   : FSM state encoding, default build parameters and width helper
//           shared by the ADC sample reader and the compensator input stage.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_sample_reader_pkg;

    localparam int c_DEF_DATA_W       = 12;
    localparam int c_DEF_SCLK_HALF    = 2;
    localparam int c_DEF_BUSY_TIMEOUT = 63;

    localparam int c_ST_W = 3;
    typedef logic [c_ST_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WAIT_HI = 3'd1;
    localparam state_t c_ST_WAIT_LO = 3'd2;
    localparam state_t c_ST_SHIFT   = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sample_reader_sync2.sv
// ============================================================================
// Module : adc_sample_reader_sync2
// Brief  : Two-flop synchroniser for a single asynchronous level input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_reader_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/adc_sample_reader.sv
// ============================================================================
// Module : adc_sample_reader
// Brief  : Tracks the ADC BUSY handshake after each convst_bar fall, reads the
//          result MSB-first over cs_n/sclk/sdo and presents it with a strobe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_reader
    import adc_sample_reader_pkg::*;
#(
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int SCLK_HALF    = c_DEF_SCLK_HALF,
    parameter int BUSY_TIMEOUT = c_DEF_BUSY_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              convst_bar,
    input  logic              adc_busy,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              timeout_err,
    output logic              overrun
);

    localparam int c_TMO_W = clog2_min1(BUSY_TIMEOUT + 1);
    localparam int c_PH_W  = clog2_min1(2 * SCLK_HALF);
    localparam int c_BIT_W = clog2_min1(DATA_W);

    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(BUSY_TIMEOUT);
    localparam logic [c_PH_W-1:0]  c_PH_RISE = c_PH_W'(SCLK_HALF - 1);
    localparam logic [c_PH_W-1:0]  c_PH_END  = c_PH_W'(2 * SCLK_HALF - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_TOP = c_BIT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_convst_prev;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_PH_W-1:0]   r_phase;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;

    logic                r_cs_n;
    logic                r_sclk;
    logic [DATA_W-1:0]   r_sample;
    logic                r_valid;
    logic                r_tmo_err;
    logic                r_overrun;

    logic                w_busy_s;
    logic                w_fall;
    logic                w_in_wait;
    logic                w_tmo_hit;
    logic                w_ph_rise;
    logic                w_ph_end;
    logic                w_last_bit;
    logic                w_enter_shift;
    logic                w_stay_shift;

    logic                w_cs_n_d;
    logic                w_sclk_d;
    logic [DATA_W-1:0]   w_sample_d;
    logic                w_valid_d;
    logic                w_tmo_err_d;
    logic                w_overrun_d;

    adc_sample_reader_sync2 u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_busy),
        .q     (w_busy_s)
    );

    assign w_fall        = r_convst_prev & ~convst_bar;
    assign w_in_wait     = (r_state == c_ST_WAIT_HI) || (r_state == c_ST_WAIT_LO);
    assign w_tmo_hit     = (r_tmo_cnt == c_TMO_MAX);
    assign w_ph_rise     = (r_phase == c_PH_RISE);
    assign w_ph_end      = (r_phase == c_PH_END);
    assign w_last_bit    = (r_bit_cnt == '0);
    assign w_enter_shift = (r_state == c_ST_WAIT_LO) && (w_state_nxt == c_ST_SHIFT);
    assign w_stay_shift  = (r_state == c_ST_SHIFT) && (w_state_nxt == c_ST_SHIFT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = c_ST_WAIT_HI;
                end
            end
            c_ST_WAIT_HI: begin
                if (w_busy_s) begin
                    w_state_nxt = c_ST_WAIT_LO;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WAIT_LO: begin
                if (!w_busy_s) begin
                    w_state_nxt = c_ST_SHIFT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_SHIFT: begin
                if (w_ph_end && w_last_bit) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Computes next output values from the transition,
    // so every port is driven straight from a flop. The DONE cycle is the
    // one where sample_valid is high and cs_n has already returned high.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_n_d    = (w_state_nxt != c_ST_SHIFT);
        w_sclk_d    = 1'b1;
        if (w_enter_shift) begin
            w_sclk_d = 1'b0;
        end else if (w_stay_shift) begin
            if (w_ph_rise) begin
                w_sclk_d = 1'b1;
            end else if (w_ph_end) begin
                w_sclk_d = 1'b0;
            end else begin
                w_sclk_d = r_sclk;
            end
        end
        w_valid_d   = (r_state == c_ST_SHIFT) && (w_state_nxt == c_ST_DONE);
        w_sample_d  = w_valid_d ? r_shift : r_sample;
        w_tmo_err_d = w_in_wait && (w_state_nxt == c_ST_IDLE);
        w_overrun_d = w_fall && (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_tmo_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cs_n    <= w_cs_n_d;
            r_sclk    <= w_sclk_d;
            r_sample  <= w_sample_d;
            r_valid   <= w_valid_d;
            r_tmo_err <= w_tmo_err_d;
            r_overrun <= w_overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: edge history, timeout, sclk phase, bit count, shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_convst_prev <= 1'b1;
            r_tmo_cnt     <= '0;
            r_phase       <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
        end else begin
            r_convst_prev <= convst_bar;

            // Restarts on entry to each wait state; holds at the limit.
            if (w_in_wait && (w_state_nxt == r_state)) begin
                if (!w_tmo_hit) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_enter_shift) begin
                r_phase   <= '0;
                r_bit_cnt <= c_BIT_TOP;
                r_shift   <= '0;
            end else if (r_state == c_ST_SHIFT) begin
                r_phase <= w_ph_end ? '0 : r_phase + 1'b1;
                if (w_ph_rise) begin
                    r_shift <= {r_shift[DATA_W-2:0], adc_sdo};
                end
                // Bit count stops at zero; the last bit ends SHIFT instead.
                if (w_ph_end && !w_last_bit) begin
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end
            end
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign timeout_err  = r_tmo_err;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
